// File: rtl/e203_nice_csr_master_pkg.sv
// Shared types and constants for the NICE CSR initiator and its timeout counter.
package e203_nice_csr_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } csr_state_e;

    localparam int          CSR_ADDR_W   = 12;
    localparam int          NICE_ADDR_W  = 32;
    localparam int          NICE_DATA_W  = 32;
    localparam logic [11:0] CSR_BASE_DEF = 12'hBC0;
    localparam logic [11:0] CSR_LAST_DEF = 12'hBFF;

    function automatic logic csr_in_range(input logic [11:0] addr,
                                          input logic [11:0] base,
                                          input logic [11:0] last);
        return (addr >= base) && (addr <= last);
    endfunction

endpackage

// File: rtl/e203_nice_csr_tmo_cnt.sv
// Saturating 8-bit wait counter; o_hit flags the last cycle before a responder timeout.
module e203_nice_csr_tmo_cnt #(
    parameter int TMO_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_hit
);

    localparam logic [7:0] HIT_VAL = 8'(TMO_CYCLES - 1);

    logic [7:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != 8'hFF)) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    assign o_hit = (r_cnt == HIT_VAL);

endmodule

// File: rtl/e203_nice_csr_master.sv
// NICE CSR initiator: forwards one custom-CSR access at a time to the responder and
// returns its result, flagging out-of-range addresses and responder timeouts as errors.
module e203_nice_csr_master
    import e203_nice_csr_master_pkg::*;
#(
    parameter logic [11:0] CSR_BASE   = CSR_BASE_DEF,
    parameter logic [11:0] CSR_LAST   = CSR_LAST_DEF,
    parameter int          TMO_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   csr_req_valid,
    output logic                   csr_req_ready,
    input  logic [CSR_ADDR_W-1:0]  csr_req_addr,
    input  logic                   csr_req_wr,
    input  logic [NICE_DATA_W-1:0] csr_req_wdata,
    output logic                   csr_rsp_valid,
    input  logic                   csr_rsp_ready,
    output logic [NICE_DATA_W-1:0] csr_rsp_rdata,
    output logic                   csr_rsp_err,
    output logic                   nice_csr_valid,
    input  logic                   nice_csr_ready,
    output logic [NICE_ADDR_W-1:0] nice_csr_addr,
    output logic                   nice_csr_wr,
    output logic [NICE_DATA_W-1:0] nice_csr_wdata,
    input  logic [NICE_DATA_W-1:0] nice_csr_rdata
);

    csr_state_e             r_state;
    csr_state_e             w_state_nxt;
    logic [CSR_ADDR_W-1:0]  r_addr;
    logic                   r_wr;
    logic [NICE_DATA_W-1:0] r_wdata;
    logic [NICE_DATA_W-1:0] r_rdata;
    logic                   r_err;

    logic                   w_accept;
    logic                   w_rsp_load;
    logic                   w_rsp_err_nxt;
    logic [NICE_DATA_W-1:0] w_rsp_rdata_nxt;
    logic                   w_cnt_en;
    logic                   w_tmo_hit;

    e203_nice_csr_tmo_cnt #(
        .TMO_CYCLES (TMO_CYCLES)
    ) u_tmo_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_accept),
        .i_en  (w_cnt_en),
        .o_hit (w_tmo_hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        csr_req_ready   = 1'b0;
        csr_rsp_valid   = 1'b0;
        nice_csr_valid  = 1'b0;
        w_accept        = 1'b0;
        w_rsp_load      = 1'b0;
        w_rsp_err_nxt   = 1'b0;
        w_rsp_rdata_nxt = '0;
        w_cnt_en        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                csr_req_ready = 1'b1;
                if (csr_req_valid) begin
                    w_accept = 1'b1;
                    if (csr_in_range(csr_req_addr, CSR_BASE, CSR_LAST)) begin
                        w_state_nxt = ST_ISSUE;
                    end else begin
                        // Out-of-range accesses never touch the responder.
                        w_state_nxt   = ST_RESP;
                        w_rsp_load    = 1'b1;
                        w_rsp_err_nxt = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                nice_csr_valid = 1'b1;
                if (nice_csr_ready) begin
                    // Ready takes priority over a timeout landing in the same cycle.
                    w_state_nxt     = ST_RESP;
                    w_rsp_load      = 1'b1;
                    w_rsp_rdata_nxt = r_wr ? '0 : nice_csr_rdata;
                end else if (w_tmo_hit) begin
                    w_state_nxt   = ST_RESP;
                    w_rsp_load    = 1'b1;
                    w_rsp_err_nxt = 1'b1;
                end else begin
                    w_cnt_en = 1'b1;
                end
            end
            ST_RESP: begin
                csr_rsp_valid = 1'b1;
                if (csr_rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr  <= '0;
            r_wr    <= 1'b0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr  <= csr_req_addr;
                r_wr    <= csr_req_wr;
                r_wdata <= csr_req_wdata;
            end
            if (w_rsp_load) begin
                r_rdata <= w_rsp_rdata_nxt;
                r_err   <= w_rsp_err_nxt;
            end
        end
    end

    // Responder and core-facing buses read as zero whenever their handshake is idle.
    assign nice_csr_addr  = nice_csr_valid ? {{(NICE_ADDR_W-CSR_ADDR_W){1'b0}}, r_addr} : '0;
    assign nice_csr_wr    = nice_csr_valid & r_wr;
    assign nice_csr_wdata = nice_csr_valid ? r_wdata : '0;
    assign csr_rsp_rdata  = csr_rsp_valid ? r_rdata : '0;
    assign csr_rsp_err    = csr_rsp_valid & r_err;

endmodule

// File: tb/tb_e203_nice_csr_master.sv
// Bench for e203_nice_csr_master: directed vector table, reset corner case and
// randomized accesses checked against a transaction-level expectation model.
module tb_e203_nice_csr_master;

    localparam int TMO = 16;

    logic        clk;
    logic        rst_n;
    logic        csr_req_valid;
    logic        csr_req_ready;
    logic [11:0] csr_req_addr;
    logic        csr_req_wr;
    logic [31:0] csr_req_wdata;
    logic        csr_rsp_valid;
    logic        csr_rsp_ready;
    logic [31:0] csr_rsp_rdata;
    logic        csr_rsp_err;
    logic        nice_csr_valid;
    logic        nice_csr_ready;
    logic [31:0] nice_csr_addr;
    logic        nice_csr_wr;
    logic [31:0] nice_csr_wdata;
    logic [31:0] nice_csr_rdata;

    int checks = 0;
    int errors = 0;

    e203_nice_csr_master #(
        .CSR_BASE   (12'hBC0),
        .CSR_LAST   (12'hBFF),
        .TMO_CYCLES (TMO)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .csr_req_valid  (csr_req_valid),
        .csr_req_ready  (csr_req_ready),
        .csr_req_addr   (csr_req_addr),
        .csr_req_wr     (csr_req_wr),
        .csr_req_wdata  (csr_req_wdata),
        .csr_rsp_valid  (csr_rsp_valid),
        .csr_rsp_ready  (csr_rsp_ready),
        .csr_rsp_rdata  (csr_rsp_rdata),
        .csr_rsp_err    (csr_rsp_err),
        .nice_csr_valid (nice_csr_valid),
        .nice_csr_ready (nice_csr_ready),
        .nice_csr_addr  (nice_csr_addr),
        .nice_csr_wr    (nice_csr_wr),
        .nice_csr_wdata (nice_csr_wdata),
        .nice_csr_rdata (nice_csr_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] addr;
        logic        wr;
        logic [31:0] wdata;
        int          delay;      // valid cycles before ready; >= TMO means never
        logic [31:0] rdata;
        int          rsp_hold;   // cycles csr_rsp_ready is held low
        bit          offer;      // offer a new request while the response waits
        int          exp_vcyc;   // expected cycles with nice_csr_valid high
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expectation derived from the access rules, not from any cycle-level state.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        bit in_rng = (v.addr >= 12'hBC0) && (v.addr <= 12'hBFF);
        bit hit    = in_rng && (v.delay < TMO);
        r.exp_vcyc  = !in_rng ? 0 : (hit ? v.delay + 1 : TMO);
        r.exp_err   = !hit;
        r.exp_rdata = (hit && !v.wr) ? v.rdata : 32'h0;
        return r;
    endfunction

    // Entered and left at posedge+1 with the DUT idle.
    task automatic run_txn(input vec_t v, input string tag);
        int  vcyc = 0;
        int  lat  = 0;
        int  bad  = 0;
        int  unstable = 0;
        bit  got  = 0;
        chk({tag, "_req_ready_idle"}, csr_req_ready, 1);
        csr_req_valid = 1'b1;
        csr_req_addr  = v.addr;
        csr_req_wr    = v.wr;
        csr_req_wdata = v.wdata;
        @(posedge clk); #1;
        csr_req_valid = 1'b0;
        csr_req_addr  = 12'($urandom);
        csr_req_wr    = ~v.wr;
        csr_req_wdata = $urandom;
        for (int c = 0; c < 300; c++) begin
            lat++;
            if (csr_rsp_valid) begin
                got = 1;
                break;
            end
            if (nice_csr_valid) begin
                if (nice_csr_addr !== {20'h0, v.addr} || nice_csr_wr !== v.wr ||
                    nice_csr_wdata !== v.wdata)
                    bad++;
                nice_csr_ready = (vcyc == v.delay);
                nice_csr_rdata = (vcyc == v.delay) ? v.rdata : $urandom;
                vcyc++;
            end else begin
                nice_csr_ready = 1'b0;
            end
            @(posedge clk); #1;
        end
        nice_csr_ready = 1'b0;
        chk({tag, "_rsp_seen"}, 32'(got), 1);
        chk({tag, "_latency"}, lat, v.exp_vcyc + 1);
        chk({tag, "_valid_cycles"}, vcyc, v.exp_vcyc);
        chk({tag, "_req_fields"}, bad, 0);
        chk({tag, "_rdata"}, csr_rsp_rdata, v.exp_rdata);
        chk({tag, "_err"}, csr_rsp_err, v.exp_err);
        chk({tag, "_nice_idle_in_resp"}, nice_csr_valid, 0);
        chk({tag, "_req_ready_resp"}, csr_req_ready, 0);
        for (int h = 0; h < v.rsp_hold; h++) begin
            if (v.offer) begin
                csr_req_valid = 1'b1;
                csr_req_addr  = 12'hBC1;
            end
            csr_rsp_ready = 1'b0;
            @(posedge clk); #1;
            if (csr_rsp_valid !== 1'b1 || csr_rsp_rdata !== v.exp_rdata ||
                csr_rsp_err !== v.exp_err || csr_req_ready !== 1'b0 || nice_csr_valid !== 1'b0)
                unstable++;
        end
        if (v.rsp_hold > 0) chk({tag, "_hold_stable"}, unstable, 0);
        csr_rsp_ready = 1'b1;
        @(posedge clk); #1;
        csr_rsp_ready = 1'b0;
        csr_req_valid = 1'b0;
        chk({tag, "_rsp_dropped"}, csr_rsp_valid, 0);
        chk({tag, "_back_to_idle"}, csr_req_ready, 1);
        chk({tag, "_no_extra_issue"}, nice_csr_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   idle_bad;

        tbl[0] = '{12'hBC3, 1'b0, 32'h0,         0,   32'hDEADBEEF, 0, 1'b0, 1,  1'b0, 32'hDEADBEEF};
        tbl[1] = '{12'hBFF, 1'b1, 32'h1234_5678, 3,   32'hA5A5A5A5, 1, 1'b0, 4,  1'b0, 32'h0};
        tbl[2] = '{12'hBC0, 1'b0, 32'h0,         255, 32'h11111111, 0, 1'b0, 16, 1'b1, 32'h0};
        tbl[3] = '{12'hBC0, 1'b0, 32'h0,         15,  32'hCAFEF00D, 0, 1'b0, 16, 1'b0, 32'hCAFEF00D};
        tbl[4] = '{12'hBBF, 1'b0, 32'h0,         0,   32'h22222222, 0, 1'b0, 0,  1'b1, 32'h0};
        tbl[5] = '{12'hC00, 1'b1, 32'hFFFF0000,  0,   32'h33333333, 0, 1'b0, 0,  1'b1, 32'h0};
        tbl[6] = '{12'hBC5, 1'b0, 32'h0,         2,   32'h0BADF00D, 5, 1'b1, 3,  1'b0, 32'h0BADF00D};
        tbl[7] = '{12'hBD0, 1'b0, 32'h0,         14,  32'h76543210, 0, 1'b0, 15, 1'b0, 32'h76543210};
        tbl[8] = '{12'hBE0, 1'b1, 32'h55AA55AA,  16,  32'h44444444, 2, 1'b1, 16, 1'b1, 32'h0};
        tbl[9] = '{12'h000, 1'b0, 32'h0,         0,   32'h66666666, 0, 1'b0, 0,  1'b1, 32'h0};

        rst_n          = 1'b1;
        csr_req_valid  = 1'b0;
        csr_req_addr   = '0;
        csr_req_wr     = 1'b0;
        csr_req_wdata  = '0;
        csr_rsp_ready  = 1'b0;
        nice_csr_ready = 1'b0;
        nice_csr_rdata = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_req_ready", csr_req_ready, 1);
        chk("rst_rsp_valid", csr_rsp_valid, 0);
        chk("rst_rsp_rdata", csr_rsp_rdata, 0);
        chk("rst_rsp_err", csr_rsp_err, 0);
        chk("rst_nice_valid", nice_csr_valid, 0);
        chk("rst_nice_addr", nice_csr_addr, 0);
        chk("rst_nice_wr", nice_csr_wr, 0);
        chk("rst_nice_wdata", nice_csr_wdata, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            run_txn(tbl[i], $sformatf("vec%0d", i));
        end

        // Reset while the responder is being driven.
        csr_req_valid = 1'b1;
        csr_req_addr  = 12'hBC7;
        csr_req_wr    = 1'b0;
        @(posedge clk); #1;
        csr_req_valid  = 1'b0;
        nice_csr_ready = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("midrst_valid_before", nice_csr_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_nice_valid_async", nice_csr_valid, 0);
        chk("midrst_nice_addr_async", nice_csr_addr, 0);
        chk("midrst_rsp_valid_async", csr_rsp_valid, 0);
        @(negedge clk) rst_n = 1'b1;
        idle_bad = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            if (csr_req_ready !== 1'b1 || csr_rsp_valid !== 1'b0 || nice_csr_valid !== 1'b0)
                idle_bad++;
        end
        chk("midrst_idle_after", idle_bad, 0);
        run_txn(model('{12'hBC9, 1'b0, 32'h0, 15, 32'h13579BDF, 0, 1'b0, 0, 1'b0, 32'h0}),
                "post_rst");

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0:       v.addr = 12'($urandom);
                1:       v.addr = ($urandom_range(0, 1) == 1) ? 12'hBBF + 12'($urandom_range(0, 2))
                                                              : 12'hBFE + 12'($urandom_range(0, 2));
                default: v.addr = 12'hBC0 + 12'($urandom_range(0, 63));
            endcase
            v.wr       = 1'($urandom);
            v.wdata    = $urandom;
            v.delay    = $urandom_range(0, 20);
            v.rdata    = $urandom;
            v.rsp_hold = $urandom_range(0, 3);
            v.offer    = 1'($urandom);
            run_txn(model(v), $sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/e203_nice_csr_master.md
Name: e203_nice_csr_master

Overview:
- Initiator side of the NICE CSR handshake.
- Accepts one custom-CSR access at a time from the core's CSR unit and drives nice_csr_valid/addr/wr/wdata toward the extended-CSR responder.
- Waits for nice_csr_ready, captures nice_csr_rdata, and returns a response with an error flag.
- Out-of-range addresses and responder timeouts are reported as errors, so the core never hangs on a dead responder.

Parameters:
- CSR_BASE, 12'hBC0, first custom CSR address handled over NICE.
- CSR_LAST, 12'hBFF, last custom CSR address handled over NICE (inclusive).
- TMO_CYCLES, 16, maximum cycles nice_csr_valid is held without nice_csr_ready before abort; legal range 2..255.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- csr_req_valid  in  1  core request valid
- csr_req_ready  out  1  block can accept a request
- csr_req_addr  in  12  CSR address
- csr_req_wr  in  1  1 = write, 0 = read
- csr_req_wdata  in  32  write data
- csr_rsp_valid  out  1  response valid
- csr_rsp_ready  in  1  core accepts response
- csr_rsp_rdata  out  32  read data (0 for writes and errors)
- csr_rsp_err  out  1  out-of-range or timeout
- nice_csr_valid  out  1  request to responder
- nice_csr_ready  in  1  responder accepts/completes
- nice_csr_addr  out  32  zero-extended CSR address
- nice_csr_wr  out  1  write flag
- nice_csr_wdata  out  32  write data
- nice_csr_rdata  in  32  responder read data, valid in the handshake cycle

Behaviour:
- Single clock clk; reset is asynchronous and active-low on rst_n. All state flops clear immediately on rst_n low.
- FSM states: IDLE, ISSUE, RESP. Reset state is IDLE.
- Reset values of outputs:
  - csr_req_ready=1 (combinational, state==IDLE).
  - csr_rsp_valid=0, csr_rsp_rdata=0, csr_rsp_err=0.
  - nice_csr_valid=0, nice_csr_addr=0, nice_csr_wr=0, nice_csr_wdata=0.
- IDLE:
  - csr_req_ready=1. A handshake (csr_req_valid & csr_req_ready) registers addr/wr/wdata.
  - If CSR_BASE <= addr <= CSR_LAST (unsigned 12-bit compare): go to ISSUE and clear the timeout counter.
  - Otherwise: go to RESP with err=1 and rdata=0; no NICE access is made.
- ISSUE:
  - nice_csr_valid=1. nice_csr_addr={20'b0,addr}, nice_csr_wr and nice_csr_wdata come from registers and stay stable for the whole state.
  - csr_req_ready=0.
  - On nice_csr_ready=1: capture rdata (read) or 0 (write), set err=0, go to RESP. The handshake completes in that single cycle.
  - If no ready, the counter increments. When the counter == TMO_CYCLES-1 and ready is still 0, abort: go to RESP with err=1, rdata=0.
  - nice_csr_valid drops in the cycle after an abort. This is the only case where valid is withdrawn without ready.
  - Ready arriving in the same cycle the counter reaches its limit counts as success; ready wins over timeout.
- RESP:
  - csr_rsp_valid=1; rdata/err held stable until csr_rsp_ready.
  - On csr_rsp_ready, go to IDLE. csr_req_ready rises the next cycle; there are no back-to-back accepts.
- Latency: request accepted in cycle N → nice_csr_valid in N+1 → if ready in N+1, csr_rsp_valid in N+2. An out-of-range request gives csr_rsp_valid in N+1.
- Counter is 8 bits wide and saturates; it never wraps.
- Only one access is outstanding at a time; request inputs are ignored outside IDLE.
- Reset mid-ISSUE or mid-RESP: nice_csr_valid and csr_rsp_valid deassert asynchronously and the in-flight access is discarded.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE=2'd0, ISSUE=2'd1, RESP=2'd2).
  - Default CSR_BASE/CSR_LAST constants.
  - NICE CSR address width (32) and data width (32) constants.
- One natural sub-module, e203_nice_csr_tmo_cnt: clear/enable/saturating counter with a hit flag at TMO_CYCLES-1.
- All other logic stays in the top module.

Test Plan:
- Read hit: req addr=12'hBC3, wr=0; responder ready in first ISSUE cycle with rdata=32'hDEADBEEF → nice_csr_addr=32'h0000_0BC3; csr_rsp_valid 2 cycles after accept with rdata=32'hDEADBEEF, err=0.
- Write hit with delay: addr=12'hBFF, wdata=32'h1234_5678; ready asserted after 3 cycles of valid → addr/wdata/wr stable for all 3 cycles; response rdata=0, err=0.
- Timeout: responder ready tied 0, TMO_CYCLES=16 → nice_csr_valid high exactly 16 cycles then drops; csr_rsp_err=1, rdata=0. Repeat with ready in the 16th cycle → success, err=0.
- Out-of-range: addr=12'hBBF and addr=12'hC00 → nice_csr_valid never asserts; response in next cycle with err=1.
- Response backpressure: csr_rsp_ready held 0 for 5 cycles → rsp_valid/rdata/err stable, csr_req_ready=0, and a new request offered meanwhile is not accepted until after the response handshake.
- Reset mid-ISSUE: rst_n pulsed low while nice_csr_valid=1 → nice_csr_valid=0 immediately; after release, IDLE with csr_req_ready=1 and no spurious response.
